// File: rtl/fsmd_max_finder_if.sv
// Handshake bundle between the max-finder and its sample source / downstream subtractor.
// The slave modport is the finder itself; the master modport is whoever drives it.
interface fsmd_max_finder_if #(
    parameter int count_width = 8
) ();

    // Scan control
    logic                   start;
    logic [count_width-1:0] last_count;
    logic                   busy;
    logic                   err_o;

    // Sample fetch
    logic                   data_req;
    logic                   data_en;
    logic [15:0]            data_i;
    logic [count_width-1:0] addr_o;

    // Result toward the subtractor
    logic                   ds_ready;
    logic [15:0]            max_o;
    logic [count_width-1:0] argmax_o;
    logic                   max_valid_o;

    modport slave (
        input  start,
        input  last_count,
        input  data_en,
        input  data_i,
        input  ds_ready,
        output data_req,
        output addr_o,
        output max_o,
        output argmax_o,
        output max_valid_o,
        output busy,
        output err_o
    );

    modport master (
        output start,
        output last_count,
        output data_en,
        output data_i,
        output ds_ready,
        input  data_req,
        input  addr_o,
        input  max_o,
        input  argmax_o,
        input  max_valid_o,
        input  busy,
        input  err_o
    );

endinterface

// File: rtl/fsmd_max_finder.sv
// Streaming max/argmax search over one vector of Q7.8 samples, feeding the
// softmax subtractor with a single-cycle result pulse once downstream is idle.
module fsmd_max_finder #(
    parameter int count_width = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fsmd_max_finder_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]             state_q,     state_d;
    logic [count_width-1:0] cnt_q,       cnt_d;
    logic [count_width-1:0] n_q,         n_d;
    logic [15:0]            max_q,       max_d;
    logic [count_width-1:0] idx_q,       idx_d;
    logic [15:0]            max_out_q,   max_out_d;
    logic [count_width-1:0] argmax_q,    argmax_d;
    logic                   valid_q,     valid_d;
    logic                   err_q,       err_d;

    logic [count_width-1:0] last_idx;
    logic                   accept;
    logic                   is_greater;

    assign last_idx   = n_q - count_width'(1);
    assign accept     = (state_q == ST_REQ) && bus.data_en;
    // Samples are Q7.8 two's complement, so 16'h8000 must rank below 16'h7FFF.
    assign is_greater = $signed(bus.data_i) > $signed(max_q);

    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch instead of plain logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        max_d     = max_q;
        idx_d     = idx_q;
        max_out_d = max_out_q;
        argmax_d  = argmax_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.last_count == '0) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = bus.last_count;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (accept) begin
                    // The first sample seeds the search so all-negative vectors work.
                    if (cnt_q == '0) begin
                        max_d = bus.data_i;
                        idx_d = '0;
                    end else if (is_greater) begin
                        max_d = bus.data_i;
                        idx_d = cnt_q;
                    end

                    if (cnt_q == last_idx) begin
                        state_d = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + count_width'(1);
                    end
                end
            end

            ST_OUT: begin
                if (bus.ds_ready) begin
                    valid_d   = 1'b1;
                    max_out_d = max_q;
                    argmax_d  = idx_q;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            max_out_q <= '0;
            argmax_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            max_out_q <= max_out_d;
            argmax_q  <= argmax_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.data_req    = (state_q == ST_REQ);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.addr_o      = cnt_q;
    assign bus.max_o       = max_out_q;
    assign bus.argmax_o    = argmax_q;
    assign bus.max_valid_o = valid_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_fsmd_max_finder.sv
// Self-checking bench for fsmd_max_finder: directed and random scans, with a
// reference max/argmax model feeding a scoreboard drained by a result monitor.
module tb_fsmd_max_finder;

    localparam int CW = 8;

    typedef logic [15:0] sample_q_t[$];
    typedef struct packed {
        logic [15:0]   max;
        logic [CW-1:0] idx;
    } result_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    result_t exp_q[$];

    fsmd_max_finder_if #(.count_width(CW)) bus ();

    fsmd_max_finder #(.count_width(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first index holding the largest signed value.
    function automatic result_t ref_max(input sample_q_t s);
        result_t r;
        r.max = s[0];
        r.idx = '0;
        for (int i = 1; i < s.size(); i++) begin
            if ($signed(s[i]) > $signed(r.max)) begin
                r.max = s[i];
                r.idx = CW'(i);
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.max_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("sb_max", {16'b0, bus.max_o}, {16'b0, e.max});
                check("sb_argmax", {24'b0, bus.argmax_o}, {24'b0, e.idx});
            end
        end
    end

    task automatic run_scan(input sample_q_t s, input int gap, input int ds_delay, input bit spurious);
        int n;
        result_t e;
        n = s.size();
        e = ref_max(s);

        if (spurious) begin
            bus.data_en = 1'b1;
            bus.data_i  = 16'h7FFF;
            tick();
            bus.data_en = 1'b0;
            check("idle_ignore_addr", {24'b0, bus.addr_o}, 32'd0);
            check("idle_ignore_busy", {31'b0, bus.busy}, 32'd0);
        end

        bus.ds_ready   = (ds_delay == 0);
        bus.start      = 1'b1;
        bus.last_count = CW'(n);
        exp_q.push_back(e);
        tick();
        bus.start      = 1'b0;
        bus.last_count = CW'($urandom_range(0, 255));

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                if (spurious) begin
                    bus.start      = 1'b1;
                    bus.last_count = 8'd1;
                end
                tick();
                bus.start = 1'b0;
            end
            check("addr_step", {24'b0, bus.addr_o}, i);
            check("data_req_on", {31'b0, bus.data_req}, 32'd1);
            bus.data_en = 1'b1;
            bus.data_i  = s[i];
            tick();
            bus.data_en = 1'b0;
        end

        check("data_req_off", {31'b0, bus.data_req}, 32'd0);
        check("busy_in_out", {31'b0, bus.busy}, 32'd1);
        check("no_early_pulse", {31'b0, bus.max_valid_o}, 32'd0);

        for (int d = 0; d < ds_delay; d++) begin
            if (spurious) begin
                bus.data_en = 1'b1;
                bus.data_i  = 16'h7FFF;
            end
            tick();
            check("hold_no_pulse", {31'b0, bus.max_valid_o}, 32'd0);
            check("hold_busy", {31'b0, bus.busy}, 32'd1);
            check("hold_no_req", {31'b0, bus.data_req}, 32'd0);
        end
        bus.data_en  = 1'b0;
        bus.ds_ready = 1'b1;

        tick();
        check("pulse_latency", {31'b0, bus.max_valid_o}, 32'd1);
        tick();
        check("pulse_single", {31'b0, bus.max_valid_o}, 32'd0);
        check("idle_after", {31'b0, bus.busy}, 32'd0);
        check("max_held", {16'b0, bus.max_o}, {16'b0, e.max});
        check("argmax_held", {24'b0, bus.argmax_o}, {24'b0, e.idx});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sample_q_t s;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.last_count = '0;
        bus.data_en    = 1'b0;
        bus.data_i     = '0;
        bus.ds_ready   = 1'b1;
        #23;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_req", {31'b0, bus.data_req}, 32'd0);
        check("rst_max", {16'b0, bus.max_o}, 32'd0);
        check("rst_valid", {31'b0, bus.max_valid_o}, 32'd0);
        check("rst_err", {31'b0, bus.err_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        s = '{16'h0100, 16'h0380, 16'hFF00, 16'h0200};
        run_scan(s, 0, 0, 1'b0);
        s = '{16'hFE00, 16'hFF80, 16'h8000};
        run_scan(s, 0, 0, 1'b0);
        s = '{16'h8000, 16'h7FFF};
        run_scan(s, 0, 0, 1'b0);
        s = '{16'h0200, 16'h0500, 16'h0500, 16'h0100};
        run_scan(s, 0, 0, 1'b0);
        s = '{16'h0300, 16'hF000, 16'h0700, 16'h0700, 16'h0010};
        run_scan(s, 2, 0, 1'b1);
        s = '{16'h1234};
        run_scan(s, 0, 0, 1'b0);
        s = '{16'h0042, 16'h0043, 16'h0041};
        run_scan(s, 0, 10, 1'b1);

        // Zero-length start: error pulse only, no scan.
        bus.start      = 1'b1;
        bus.last_count = '0;
        tick();
        bus.start = 1'b0;
        check("err_pulse", {31'b0, bus.err_o}, 32'd1);
        check("err_not_busy", {31'b0, bus.busy}, 32'd0);
        tick();
        check("err_single", {31'b0, bus.err_o}, 32'd0);
        check("err_still_idle", {31'b0, bus.busy}, 32'd0);

        // Reset after two samples of a five-sample scan.
        bus.start      = 1'b1;
        bus.last_count = 8'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.data_en = 1'b1;
            bus.data_i  = 16'h0600 + 16'(i);
            tick();
        end
        bus.data_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_req", {31'b0, bus.data_req}, 32'd0);
        check("midrst_addr", {24'b0, bus.addr_o}, 32'd0);
        check("midrst_max", {16'b0, bus.max_o}, 32'd0);
        check("midrst_argmax", {24'b0, bus.argmax_o}, 32'd0);
        check("midrst_valid", {31'b0, bus.max_valid_o}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", {31'b0, bus.busy}, 32'd0);
        s = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0001, 16'h0000};
        run_scan(s, 1, 2, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int n;
            s = {};
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 9))
                    0:       s.push_back(16'h8000);
                    1:       s.push_back(16'h7FFF);
                    2:       s.push_back(16'h0100);
                    default: s.push_back(16'($urandom));
                endcase
            end
            run_scan(s, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
